// File: rtl/pipe_pkg.sv
// Shared encodings for the PIPE control slice: status codes, icodes and the
// control FSM state type.
package pipe_pkg;

    localparam logic [3:0] S_AOK = 4'b1000;
    localparam logic [3:0] S_HLT = 4'b0100;
    localparam logic [3:0] S_ADR = 4'b0010;
    localparam logic [3:0] S_INS = 4'b0001;

    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_MRMOVQ = 4'h5;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_HALT
    } state_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clear)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 PIPE control: stall/bubble decisions, condition codes, power-up flush,
// halt freeze and saturating performance counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int INIT_CYCLES = 5,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    input  logic             alu_zf,
    input  logic             alu_sf,
    input  logic             alu_of,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic             halted,
    output logic [3:0]       final_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    localparam int IW = $clog2(INIT_CYCLES + 1);

    state_t        state, state_nx;
    logic [IW-1:0] init_cnt;
    logic          lu, mp, rt, exc, run, set_cc;

    assign lu  = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign mp  = (E_icode == I_JXX) && !e_Cnd;
    assign rt  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign exc = (m_stat != S_AOK) || (W_stat != S_AOK);

    assign run    = (state == ST_RUN);
    assign set_cc = run && (E_icode == I_OPQ) && !exc;
    assign halted = (state == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            cc_zf      <= 1'b1;
            cc_sf      <= 1'b0;
            cc_of      <= 1'b0;
            final_stat <= S_AOK;
        end else begin
            state <= state_nx;
            if (state == ST_INIT)
                init_cnt <= init_cnt + 1'b1;
            if (set_cc) begin
                cc_zf <= alu_zf;
                cc_sf <= alu_sf;
                cc_of <= alu_of;
            end
            if (run && (W_stat != S_AOK))
                final_stat <= W_stat;
        end
    end

    always_comb begin
        state_nx = state;
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        case (state)
            ST_INIT: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                if (init_cnt == IW'(INIT_CYCLES - 1))
                    state_nx = ST_RUN;
            end
            ST_RUN: begin
                // a load-use stall on D takes priority over the ret bubble
                F_stall  = lu | rt;
                D_stall  = lu;
                D_bubble = mp | (!lu & rt);
                E_bubble = mp | lu;
                M_bubble = exc;
                W_stall  = (W_stat != S_AOK);
                if (W_stat != S_AOK)
                    state_nx = ST_HALT;
            end
            ST_HALT: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
            default: state_nx = ST_INIT;
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk(clk), .clear(rst), .inc(run), .cnt(cyc_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk(clk), .clear(rst), .inc(run & lu), .cnt(lu_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_mp_cnt (
        .clk(clk), .clear(rst), .inc(run & mp), .cnt(mp_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_ret_cnt (
        .clk(clk), .clear(rst), .inc(run & rt & !lu), .cnt(ret_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver queues hand-computed expectations
// per cycle, a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, m_stat, W_stat;
    logic          e_Cnd, alu_zf, alu_sf, alu_of;
    logic          F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic          cc_zf, cc_sf, cc_of, halted;
    logic [3:0]    final_stat;
    logic [CW-1:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

    pipe_ctrl #(.INIT_CYCLES(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
        .halted(halted), .final_stat(final_stat),
        .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
    );

    always #5 clk = ~clk;

    // ctrl bit order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    // csel: 0 none, 1 cyc_cnt, 2 lu_cnt, 3 mp_cnt, 4 ret_cnt
    typedef struct {
        string      name;
        logic [5:0] ctrl;
        logic [2:0] cc;
        logic       hlt;
        logic [3:0] fstat;
        int         csel;
        int         cval;
    } exp_t;

    localparam logic [5:0] FLUSH = 6'b101110;
    localparam logic [5:0] FROZE = 6'b111111;

    exp_t q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int cnt_of(input int sel);
        case (sel)
            1:       return int'(cyc_cnt);
            2:       return int'(lu_cnt);
            3:       return int'(mp_cnt);
            default: return int'(ret_cnt);
        endcase
    endfunction

    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            cmp({e.name, ".ctrl"}, int'({F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}),
                int'(e.ctrl));
            cmp({e.name, ".cc"}, int'({cc_zf, cc_sf, cc_of}), int'(e.cc));
            cmp({e.name, ".halted"}, int'(halted), int'(e.hlt));
            cmp({e.name, ".final_stat"}, int'(final_stat), int'(e.fstat));
            if (e.csel != 0)
                cmp($sformatf("%s.cnt%0d", e.name, e.csel), cnt_of(e.csel), e.cval);
        end
    end

    task automatic idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        d_srcA = RNONE; d_srcB = RNONE; E_dstM = RNONE;
        e_Cnd = 1'b0; m_stat = S_AOK; W_stat = S_AOK;
        alu_zf = 1'b0; alu_sf = 1'b0; alu_of = 1'b0;
    endtask

    task automatic step(input string nm, input logic [5:0] ctrl, input logic [2:0] cc,
                        input logic hlt, input logic [3:0] fs, input int csel, input int cval);
        exp_t x;
        x.name = nm; x.ctrl = ctrl; x.cc = cc; x.hlt = hlt;
        x.fstat = fs; x.csel = csel; x.cval = cval;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        step("reset", FLUSH, 3'b100, 0, S_AOK, 1, 0);
        for (int i = 1; i < 5; i++) step("init", FLUSH, 3'b100, 0, S_AOK, 0, 0);

        step("run0", 6'b000000, 3'b100, 0, S_AOK, 1, 0);
        E_icode = I_MRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
        step("lu_mrmov", 6'b110100, 3'b100, 0, S_AOK, 2, 0);
        idle();
        step("lu_cnt1", 6'b000000, 3'b100, 0, S_AOK, 2, 1);
        E_icode = I_POPQ;
        step("lu_rnone", 6'b000000, 3'b100, 0, S_AOK, 2, 1);
        E_dstM = 4'd4; d_srcB = 4'd4;
        step("lu_popq", 6'b110100, 3'b100, 0, S_AOK, 2, 1);
        idle(); E_icode = I_JXX; e_Cnd = 1'b0;
        step("mispredict", 6'b001100, 3'b100, 0, S_AOK, 2, 2);
        e_Cnd = 1'b1;
        step("jxx_taken", 6'b000000, 3'b100, 0, S_AOK, 3, 1);
        idle(); D_icode = I_RET;
        for (int i = 0; i < 3; i++) step("ret", 6'b101000, 3'b100, 0, S_AOK, 4, i);
        idle(); E_icode = I_MRMOVQ; E_dstM = 4'd2; d_srcB = 4'd2; M_icode = I_RET;
        step("lu_and_ret", 6'b110100, 3'b100, 0, S_AOK, 4, 3);
        idle();
        step("ret_cnt", 6'b000000, 3'b100, 0, S_AOK, 4, 3);
        step("lu_cnt3", 6'b000000, 3'b100, 0, S_AOK, 2, 3);
        E_icode = I_OPQ; alu_zf = 1'b0; alu_sf = 1'b1; alu_of = 1'b1;
        step("set_cc", 6'b000000, 3'b100, 0, S_AOK, 3, 1);
        idle();
        step("cc_new", 6'b000000, 3'b011, 0, S_AOK, 1, 14);
        E_icode = I_OPQ; alu_zf = 1'b1; m_stat = S_ADR;
        step("exc_no_cc", 6'b000010, 3'b011, 0, S_AOK, 0, 0);
        idle();
        step("cc_kept", 6'b000000, 3'b011, 0, S_AOK, 0, 0);

        E_icode = I_OPQ; alu_zf = 1'b1; alu_sf = 1'b1; alu_of = 1'b1; W_stat = S_HLT;
        step("halt_entry", 6'b000011, 3'b011, 0, S_AOK, 1, 17);
        idle();
        step("halted", FROZE, 3'b011, 1, S_HLT, 1, 18);
        D_icode = I_RET; E_icode = I_MRMOVQ; E_dstM = 4'd1; d_srcA = 4'd1;
        step("halt_frz_ret", FROZE, 3'b011, 1, S_HLT, 4, 3);
        idle();
        step("halt_frz_lu", FROZE, 3'b011, 1, S_HLT, 2, 3);
        step("halt_frz_cyc", FROZE, 3'b011, 1, S_HLT, 1, 18);

        rst = 1'b1;
        step("rst_in_halt", FROZE, 3'b011, 1, S_HLT, 0, 0);
        rst = 1'b0;
        step("rst_after_halt", FLUSH, 3'b100, 0, S_AOK, 1, 0);
        step("rst_ret_clr", FLUSH, 3'b100, 0, S_AOK, 4, 0);
        rst = 1'b1;
        step("rst_in_init", FLUSH, 3'b100, 0, S_AOK, 2, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step("reinit", FLUSH, 3'b100, 0, S_AOK, 1, 0);
        for (int r = 0; r < 66; r++)
            step("sat", 6'b000000, 3'b100, 0, S_AOK,
                 (r == 0 || r == 62 || r == 63 || r == 65) ? 1 : 0, (r > 63) ? 63 : r);

        repeat (3) @(negedge clk);
        cmp("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
